// File: rtl/dcache_if.sv
// Load/store port between the memory unit and the data cache, plus the
// cache's request/acknowledge port toward main memory.
interface dcache_if;
    // Requester side: rw_flag acts as valid and is taken only while busy=0;
    // done pulses once per accepted request. Memory side: mem_req is valid,
    // mem_ack is a one-cycle ready, and mem_* stay stable until mem_ack.
    logic [1:0]  rw_flag;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [3:0]  write_mask;
    logic        busy;
    logic        done;
    logic [31:0] read_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output rw_flag, addr, write_data, write_mask, mem_rdata, mem_ack,
        input  busy, done, read_data, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
    );

    modport slave (
        input  rw_flag, addr, write_data, write_mask, mem_rdata, mem_ack,
        output busy, done, read_data, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word
// lines; one request in flight, misses and all stores go to memory.
module dcache #(
    parameter int LINES = 64,
    parameter int IDX_W = 6
) (
    input  logic       clk,
    input  logic       rst,
    dcache_if.slave    bus,
    output logic [2:0] dbg_state
);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, MEM_RD, MEM_WR, RESP} state_e;

    state_e             state_q, state_d;
    logic [1:0]         rw_q, rw_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         wmask_q, wmask_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic [3:0]         mem_wmask_q, mem_wmask_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q [LINES];
    logic [31:0]        data_q [LINES];

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic               hit;
    logic [31:0]        merged;
    logic               line_we;
    logic [31:0]        line_wdata;

    assign idx = addr_q[IDX_W+1:2];
    assign tag = addr_q[31:IDX_W+2];
    assign hit = valid_q[idx] && (tag_q[idx] == tag);

    always_comb begin
        merged = data_q[idx];
        for (int i = 0; i < 4; i++) begin
            if (wmask_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
        end
    end

    always_comb begin
        state_d     = state_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        busy_d      = busy_q;
        done_d      = done_q;
        rdata_d     = rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        valid_d     = valid_q;
        line_we     = 1'b0;
        line_wdata  = merged;
        case (state_q)
            IDLE: begin
                if (bus.rw_flag == 2'd1 || bus.rw_flag == 2'd2) begin
                    rw_d    = bus.rw_flag;
                    addr_d  = bus.addr;
                    wdata_d = bus.write_data;
                    wmask_d = bus.write_mask;
                    busy_d  = 1'b1;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (rw_q == 2'd1) begin
                    if (hit) begin
                        rdata_d = data_q[idx];
                        done_d  = 1'b1;
                        state_d = RESP;
                    end else begin
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = addr_q & 32'hFFFF_FFFC;
                        state_d    = MEM_RD;
                    end
                end else begin
                    // Store hit updates the word in place; tag and valid are untouched.
                    line_we     = hit;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q & 32'hFFFF_FFFC;
                    mem_wdata_d = wdata_q;
                    mem_wmask_d = wmask_q;
                    state_d     = MEM_WR;
                end
            end
            MEM_RD: begin
                if (bus.mem_ack) begin
                    line_we      = 1'b1;
                    line_wdata   = bus.mem_rdata;
                    valid_d[idx] = 1'b1;
                    rdata_d      = bus.mem_rdata;
                    mem_req_d    = 1'b0;
                    done_d       = 1'b1;
                    state_d      = RESP;
                end
            end
            MEM_WR: begin
                if (bus.mem_ack) begin
                    mem_req_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rw_q        <= 2'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            wmask_q     <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rdata_q     <= 32'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_wmask_q <= 4'd0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            valid_q     <= valid_d;
        end
    end

    // Tag/data storage needs no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= line_wdata;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.read_data = rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wmask = mem_wmask_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_dcache.sv
// Bench for dcache: vector table of directed requests, hand sequences for
// reset-mid-miss and back-to-back, then a randomized phase against a model.
module tb_dcache;
  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;
  dcache_if   dut_if ();

  dcache #(.LINES(64), .IDX_W(6)) dut (
    .clk(clk), .rst(rst), .bus(dut_if.slave), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] mrdata;
    int          delay;
    bit          exp_mem;
    logic [31:0] exp_rdata;
  } vec_t;

  logic [31:0] exp_q [$];
  int          pass_cnt = 0;
  int          total_cnt = 0;

  logic        m_valid [64];
  logic [23:0] m_tag [64];
  logic [31:0] m_data [64];
  logic [31:0] mem_m [logic [31:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [1:0] rw, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] wm, input logic [31:0] mr, input int d,
                              input bit em, input logic [31:0] er);
    vec_t v;
    v.rw = rw; v.addr = a; v.wdata = wd; v.wmask = wm;
    v.mrdata = mr; v.delay = d; v.exp_mem = em; v.exp_rdata = er;
    return v;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] wm);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (wm[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Drives one request, plays memory, and checks handshake, latency and data.
  task automatic run_req(input vec_t v);
    int cyc, lat, nreq, wait_c;
    bit got_done, acked, prev_req;
    logic [31:0] got_addr, got_wdata, got_rdata, e;
    logic got_we;
    logic [3:0] got_mask;
    @(negedge clk);
    dut_if.rw_flag = v.rw; dut_if.addr = v.addr;
    dut_if.write_data = v.wdata; dut_if.write_mask = v.wmask;
    if (v.rw == 2'd1) exp_q.push_back(v.exp_rdata);
    cyc = 0; lat = 0; nreq = 0; wait_c = 0; got_done = 0; acked = 0; prev_req = 0;
    got_addr = '0; got_wdata = '0; got_we = 0; got_mask = '0; got_rdata = '0;
    while (!got_done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      dut_if.rw_flag = 2'd0;
      dut_if.mem_ack = 1'b0;
      if (dut_if.mem_req && !prev_req) begin
        nreq++;
        got_addr = dut_if.mem_addr; got_we = dut_if.mem_we;
        got_wdata = dut_if.mem_wdata; got_mask = dut_if.mem_wmask;
      end
      prev_req = dut_if.mem_req;
      if (dut_if.done) begin
        got_done = 1; lat = cyc; got_rdata = dut_if.read_data;
      end else if (dut_if.mem_req && !acked) begin
        if (wait_c == v.delay) begin
          dut_if.mem_ack = 1'b1; dut_if.mem_rdata = v.mrdata; acked = 1;
        end
        wait_c++;
      end
    end
    chk("done_seen", 32'(got_done), 32'd1);
    chk("latency", lat, v.exp_mem ? 3 + v.delay : 2);
    chk("mem_req_count", nreq, v.exp_mem ? 1 : 0);
    chk("mem_req_dropped", 32'(dut_if.mem_req), 32'd0);
    if (nreq > 0) begin
      chk("mem_addr", got_addr, {v.addr[31:2], 2'b00});
      chk("mem_we", 32'(got_we), (v.rw == 2'd2) ? 32'd1 : 32'd0);
      if (v.rw == 2'd2) begin
        chk("mem_wdata", got_wdata, v.wdata);
        chk("mem_wmask", 32'(got_mask), 32'(v.wmask));
      end
    end
    if (v.rw == 2'd1 && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("read_data", got_rdata, e);
    end
    @(negedge clk);
    chk("done_one_cycle", 32'(dut_if.done), 32'd0);
    chk("busy_after", 32'(dut_if.busy), 32'd0);
  endtask

  vec_t        tbl [14];
  logic [31:0] pool [6];
  logic        exp_busy [7];
  logic        exp_done [7];

  initial begin
    logic [31:0] e, a, m, wd;
    logic [3:0]  wm;
    logic [23:0] t;
    int          li, cnt;
    bit          seen, h;

    dut_if.rw_flag = 2'd0; dut_if.addr = '0; dut_if.write_data = '0;
    dut_if.write_mask = '0; dut_if.mem_rdata = '0; dut_if.mem_ack = 1'b0;
    rst = 1'b1;

    tbl[0]  = mk(2'd1, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, 3, 1, 32'hDEADBEEF);
    tbl[1]  = mk(2'd1, 32'h102, 32'h0, 4'h0, 32'h0,        0, 0, 32'hDEADBEEF);
    tbl[2]  = mk(2'd2, 32'h101, 32'h0000AA00, 4'b0010, 32'h0, 0, 1, 32'h0);
    tbl[3]  = mk(2'd1, 32'h100, 32'h0, 4'h0, 32'h0,        0, 0, 32'hDEADAAEF);
    tbl[4]  = mk(2'd2, 32'h300, 32'h12345678, 4'hF, 32'h0, 1, 1, 32'h0);
    tbl[5]  = mk(2'd1, 32'h300, 32'h0, 4'h0, 32'h12345678, 0, 1, 32'h12345678);
    tbl[6]  = mk(2'd1, 32'h100, 32'h0, 4'h0, 32'h11111111, 2, 1, 32'h11111111);
    tbl[7]  = mk(2'd1, 32'h200, 32'h0, 4'h0, 32'h22222222, 0, 1, 32'h22222222);
    tbl[8]  = mk(2'd1, 32'h100, 32'h0, 4'h0, 32'h33333333, 1, 1, 32'h33333333);
    tbl[9]  = mk(2'd2, 32'h104, 32'hFFFFFFFF, 4'h0, 32'h0, 0, 1, 32'h0);
    tbl[10] = mk(2'd1, 32'h104, 32'h0, 4'h0, 32'hCAFEF00D, 2, 1, 32'hCAFEF00D);
    tbl[11] = mk(2'd1, 32'h106, 32'h0, 4'h0, 32'h0,        0, 0, 32'hCAFEF00D);
    tbl[12] = mk(2'd2, 32'h104, 32'hAB0000CD, 4'b1001, 32'h0, 0, 1, 32'h0);
    tbl[13] = mk(2'd1, 32'h104, 32'h0, 4'h0, 32'h0,        0, 0, 32'hABFEF0CD);

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(dut_if.busy), 32'd0);
    chk("rst_done", 32'(dut_if.done), 32'd0);
    chk("rst_read_data", dut_if.read_data, 32'd0);
    chk("rst_mem_req", 32'(dut_if.mem_req), 32'd0);
    chk("rst_mem_we", 32'(dut_if.mem_we), 32'd0);
    chk("rst_mem_addr", dut_if.mem_addr, 32'd0);
    chk("rst_mem_wdata", dut_if.mem_wdata, 32'd0);
    chk("rst_mem_wmask", 32'(dut_if.mem_wmask), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;

    for (int n = 0; n < 14; n++) run_req(tbl[n]);

    // rw_flag=3 is not a request.
    @(negedge clk);
    dut_if.rw_flag = 2'd3;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("rw3_ignored", 32'(dut_if.busy), 32'd0);
    end
    dut_if.rw_flag = 2'd0;

    // Reset while a read miss waits on memory; line 0x104 was a hit before.
    @(negedge clk);
    dut_if.rw_flag = 2'd1; dut_if.addr = 32'h400;
    seen = 0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      dut_if.rw_flag = 2'd0;
      if (dut_if.mem_req) seen = 1;
    end
    chk("rmid_req_seen", 32'(seen), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rmid_mem_req", 32'(dut_if.mem_req), 32'd0);
    chk("rmid_busy", 32'(dut_if.busy), 32'd0);
    chk("rmid_done", 32'(dut_if.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dut_if.mem_ack = 1'b1; dut_if.mem_rdata = 32'h0BAD0BAD;
    @(negedge clk);
    dut_if.mem_ack = 1'b0;
    for (int n = 0; n < 2; n++) begin
      chk("late_ack_busy", 32'(dut_if.busy), 32'd0);
      chk("late_ack_done", 32'(dut_if.done), 32'd0);
      @(negedge clk);
    end
    run_req(mk(2'd1, 32'h104, 32'h0, 4'h0, 32'h5A5A0104, 1, 1, 32'h5A5A0104));

    // Back-to-back: rw_flag held through done, new address, both hit line 1.
    exp_busy = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_done = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    @(negedge clk);
    dut_if.rw_flag = 2'd1; dut_if.addr = 32'h104;
    exp_q.push_back(32'h5A5A0104);
    exp_q.push_back(32'h5A5A0104);
    cnt = 0;
    for (int n = 0; n < 7; n++) begin
      @(negedge clk);
      if (n == 0) dut_if.addr = 32'h106;
      if (n == 4) dut_if.rw_flag = 2'd0;
      chk("b2b_busy", 32'(dut_if.busy), 32'(exp_busy[n]));
      chk("b2b_done", 32'(dut_if.done), 32'(exp_done[n]));
      if (dut_if.done) begin
        cnt++;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("b2b_read_data", dut_if.read_data, e);
        end
      end
    end
    chk("b2b_done_count", cnt, 2);

    // Randomized mix against a cache and memory model.
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    m_valid[1] = 1'b1; m_tag[1] = 24'h000001; m_data[1] = 32'h5A5A0104;
    mem_m[32'h104] = 32'h5A5A0104;
    pool = '{32'h000, 32'h100, 32'h200, 32'h104, 32'h204, 32'h008};
    for (int n = 0; n < 16; n++) begin
      a = pool[$urandom_range(0, 5)];
      li = int'(a[7:2]);
      t = a[31:8];
      if (!mem_m.exists(a)) mem_m[a] = a ^ 32'h5EED0000;
      m = mem_m[a];
      h = m_valid[li] && (m_tag[li] == t);
      if ($urandom_range(0, 1) == 1) begin
        run_req(mk(2'd1, a, 32'h0, 4'h0, m, $urandom_range(0, 3), !h, h ? m_data[li] : m));
        if (!h) begin
          m_valid[li] = 1'b1; m_tag[li] = t; m_data[li] = m;
        end
      end else begin
        wd = $urandom;
        wm = 4'($urandom_range(0, 15));
        mem_m[a] = merge(m, wd, wm);
        if (h) m_data[li] = merge(m_data[li], wd, wm);
        run_req(mk(2'd2, a, wd, wm, 32'h0, $urandom_range(0, 3), 1, 32'h0));
      end
    end

    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/dcache.md
# dcache

Direct-mapped, write-through, no-write-allocate data cache that answers the memory unit's load/store requests on the dcache side of the mem/dcache interface. It serves one request at a time, holding `busy` until a one-cycle `done` pulse. Misses and all stores go to a simple request/acknowledge port toward main memory.

## Interface
- `LINES`, 64: number of one-word lines; power of two ≥ 2.
- `IDX_W`, 6: log2(`LINES`).
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rw_flag` in 2: 0 no request, 1 read, 2 write; 3 is ignored as no request.
- `addr` in 32: byte address; `addr[1:0]` is ignored for lookup.
- `write_data` in 32: store data, already lane-aligned.
- `write_mask` in 4: byte enables; bit i enables byte lane i.
- `busy` out 1: request in progress.
- `done` out 1: one-cycle completion pulse.
- `read_data` out 32: full aligned word; valid while `done`=1 on reads.
- `mem_req` out 1: memory request; held until acknowledged.
- `mem_we` out 1: 1 for write, 0 for read.
- `mem_addr` out 32: word-aligned address {`addr[31:2]`, 2'b00}.
- `mem_wdata` out 32: write data to memory.
- `mem_wmask` out 4: byte enables to memory.
- `mem_rdata` in 32: read word; sampled when `mem_ack`=1.
- `mem_ack` in 1: one-cycle acknowledge of the current `mem_req`.

## Operation
- Address split: index = `addr[IDX_W+1:2]`; tag = `addr[31:IDX_W+2]`. Each line holds a valid bit, a tag and one 32-bit word.
- States: IDLE, LOOKUP, MEM_RD, MEM_WR, RESP.
- IDLE: if `rw_flag` is 1 or 2, latch `rw_flag`, `addr`, `write_data` and `write_mask`, then go to LOOKUP. Inputs are not sampled again until the next IDLE.
- LOOKUP, read hit: load `read_data` from the line, go to RESP.
- LOOKUP, read miss: go to MEM_RD.
- LOOKUP, write: on a hit, merge the masked bytes into the line; the tag and valid bit are unchanged. Then go to MEM_WR.
- Write miss: the cache is not modified.
- MEM_RD: `mem_req`=1, `mem_we`=0. On `mem_ack`: write `mem_rdata` into the line, set valid, set the tag, copy the word to `read_data`, go to RESP.
- MEM_WR: `mem_req`=1, `mem_we`=1, `mem_wdata`/`mem_wmask` come from the latched values. On `mem_ack`, go to RESP.
- A write with `write_mask`=0 still performs the MEM_WR handshake.
- RESP: `done`=1 for exactly this cycle, then go to IDLE.
- `busy`=1 in LOOKUP, MEM_RD, MEM_WR and RESP; 0 only in IDLE.
- The requester samples `busy`/`done`. It must drop `rw_flag` to 0 by the cycle after `done`. A nonzero `rw_flag` seen in IDLE is always a new request.
- `read_data` keeps its last value outside RESP. For writes its value is unspecified but stable.
- Replacement: a fill always overwrites the indexed line (conflict eviction). Nothing is ever dirty, so no writeback exists.

## Timing
- All outputs are registered.
- Reset values: `busy`=0, `done`=0, `read_data`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wmask`=0, state=IDLE, all valid bits=0.
- Read hit: request sampled at edge E0, `busy`=1 after E0, `done`=1 after E1, `busy`=0 after E2. That is 2 cycles from acceptance to `done`.
- Read miss or any write: `mem_req` rises after E1. If `mem_ack` is sampled at edge Ek, `done`=1 after Ek and `busy`=0 after Ek+1. With a same-cycle ack that is 3 cycles to `done`.
- Handshake with memory:
  - `mem_req` and all `mem_*` outputs stay stable until `mem_ack`.
  - `mem_req` drops the cycle after `mem_ack`.
  - `mem_ack` while `mem_req`=0 is ignored.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous), which drops `mem_req` without waiting for `mem_ack`. Pending requests are lost and every line is invalidated. A `mem_ack` arriving after reset is ignored.
- Back-to-back requests: a request held through the RESP cycle is accepted in the following IDLE cycle. The minimum `busy`-low gap is 1 cycle.

## Test plan
- Cold read miss: read 0x100; memory acks after 3 cycles with 0xDEADBEEF.
  - Required: exactly one `mem_req` (`mem_we`=0, `mem_addr`=0x100).
  - Required: one `done` with `read_data`=0xDEADBEEF.
  - Then read 0x102: hit, no `mem_req`, `done` 2 cycles after acceptance, `read_data`=0xDEADBEEF.
- Store byte to a hit line: line 0x100 holds 0xDEADBEEF; write addr 0x101, `write_mask`=0010, `write_data`=0x0000AA00.
  - Required: `mem_wmask`=0010, `mem_addr`=0x100.
  - Required: a following read of 0x100 hits with 0xDEADAAEF.
- Write miss, no allocate: write 0x300, mask 1111, data 0x12345678.
  - Required: one memory write.
  - Required: the next read of 0x300 misses (issues `mem_req`).
- Conflict eviction: read 0x100 (miss, fill 0x11111111), then read 0x200 (same index 0; miss, fill 0x22222222).
  - Required: a re-read of 0x100 misses again and returns the memory value.
- Reset mid-miss: assert `rst` while in MEM_RD with `mem_req`=1.
  - Required: `mem_req`, `busy`, `done` are 0 before the next edge.
  - Required: a late `mem_ack` is ignored.
  - Required: after release, re-reading the prior hit line misses.
- Back-to-back: hold `rw_flag`=1 through `done`, with a new `addr`.
  - Required: the second request is accepted in the IDLE cycle after RESP.
  - Required: each request produces one `done` pulse, with `busy` low for exactly 1 cycle between them.
